// File: rtl/filt_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : filt_cfg_ctrl
// Description : Configuration and readout sequencer for the filter pipeline.
//               Loads a 5x5 FIR kernel into a shadow bank and commits it at
//               frame start; drains the luminance histogram over a
//               ready/saved handshake at each frame start, then clears it.
// Revision    : 1.0 - initial release
// ============================================================================
module filt_cfg_ctrl #(
    parameter int COEF_NUM = 25,
    parameter int COEF_W   = 16,
    parameter int BIN_NUM  = 256,
    parameter int BIN_W    = 16,
    parameter int POL_VS   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         vs_i,
    input  logic                         fir_coef_write,
    input  logic [COEF_W-1:0]            fir_coef_data,
    output logic [COEF_NUM*COEF_W-1:0]   coef_o,
    output logic                         coef_commit_o,
    output logic                         coef_err_o,
    output logic                         hist_rd_en_o,
    output logic [$clog2(BIN_NUM)-1:0]   hist_rd_addr_o,
    input  logic [BIN_W-1:0]             hist_rd_data_i,
    output logic                         hist_clr_o,
    output logic [BIN_W-1:0]             hist_bin_data,
    output logic                         hist_bin_ready,
    input  logic                         hist_bin_saved,
    output logic                         hist_busy_o,
    output logic                         hist_ovr_o,
    input  logic                         err_clr_i
);

    localparam int ADDR_W = $clog2(BIN_NUM);
    localparam int IDX_W  = $clog2(COEF_NUM + 1);
    localparam int BANK_W = COEF_NUM * COEF_W;
    localparam logic [IDX_W-1:0]  IDX_FULL   = IDX_W'(COEF_NUM);
    localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(BIN_NUM - 1);
    // Identity kernel: only the centre tap is 1.
    localparam logic [BANK_W-1:0] COEF_IDENT = BANK_W'(1) << ((COEF_NUM / 2) * COEF_W);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WAIT = 3'd2,
        S_PRES = 3'd3,
        S_CLR  = 3'd4
    } hist_state_t;

    logic              vs_n;
    logic              vs_q;
    logic              fs;
    logic [IDX_W-1:0]  idx;
    logic [BANK_W-1:0] shadow;
    logic              coef_err_set;
    hist_state_t       state;
    hist_state_t       state_nxt;
    logic [ADDR_W-1:0] addr;

    // Normalise sync polarity; frame start is the rising edge of vs_n.
    assign vs_n = (POL_VS != 0) ? vs_i : ~vs_i;
    assign fs   = vs_n & ~vs_q;

    // Delayed sync for edge detection; 0 after reset so a high sync at
    // release is treated as a frame start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vs_q <= 1'b0;
        end else begin
            vs_q <= vs_n;
        end
    end

    // Error events: a partial bank at frame start, or a write into a full
    // bank that is not rescued by a coincident frame start.
    always_comb begin
        coef_err_set = 1'b0;
        if (fs && (idx != '0) && (idx != IDX_FULL)) begin
            coef_err_set = 1'b1;
        end
        if (!fs && fir_coef_write && (idx == IDX_FULL)) begin
            coef_err_set = 1'b1;
        end
    end

    // Shadow loading and atomic commit; the frame-start action is applied
    // before a coincident write, which then lands at index 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx           <= '0;
            shadow        <= '0;
            coef_o        <= COEF_IDENT;
            coef_commit_o <= 1'b0;
            coef_err_o    <= 1'b0;
        end else begin
            coef_commit_o <= fs && (idx == IDX_FULL);
            coef_err_o    <= coef_err_set | (coef_err_o & ~err_clr_i);
            if (fs && (idx == IDX_FULL)) begin
                coef_o <= shadow;
            end
            if (fs) begin
                if (fir_coef_write) begin
                    shadow[0 +: COEF_W] <= fir_coef_data;
                    idx                 <= IDX_W'(1);
                end else begin
                    idx <= '0;
                end
            end else if (fir_coef_write && (idx != IDX_FULL)) begin
                shadow[int'(idx) * COEF_W +: COEF_W] <= fir_coef_data;
                idx                                  <= idx + 1'b1;
            end
        end
    end

    // Dump state, bin address, presented data and the overrun flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            addr          <= '0;
            hist_bin_data <= '0;
            hist_ovr_o    <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state == S_IDLE) && fs) begin
                addr <= '0;
            end else if ((state == S_PRES) && hist_bin_saved && (addr != ADDR_LAST)) begin
                addr <= addr + 1'b1;
            end
            if (state == S_WAIT) begin
                hist_bin_data <= hist_rd_data_i;
            end
            hist_ovr_o <= (fs && (state != S_IDLE)) | (hist_ovr_o & ~err_clr_i);
        end
    end

    // Next-state and handshake/memory outputs of the dump sequencer.
    always_comb begin
        state_nxt      = state;
        hist_rd_en_o   = 1'b0;
        hist_rd_addr_o = addr;
        hist_bin_ready = 1'b0;
        hist_clr_o     = 1'b0;
        hist_busy_o    = 1'b1;
        case (state)
            S_IDLE: begin
                hist_busy_o = 1'b0;
                if (fs) begin
                    state_nxt = S_RD;
                end
            end
            S_RD: begin
                hist_rd_en_o = 1'b1;
                state_nxt    = S_WAIT;
            end
            S_WAIT: begin
                state_nxt = S_PRES;
            end
            S_PRES: begin
                hist_bin_ready = 1'b1;
                if (hist_bin_saved) begin
                    state_nxt = (addr == ADDR_LAST) ? S_CLR : S_RD;
                end
            end
            S_CLR: begin
                hist_clr_o = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_filt_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_filt_cfg_ctrl
// Description : Self-checking bench for filt_cfg_ctrl; histogram bins are
//               checked against a queue of expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_filt_cfg_ctrl;

    localparam int COEF_NUM = 25;
    localparam int COEF_W   = 16;
    localparam int BIN_NUM  = 256;
    localparam int BIN_W    = 16;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       vs_i;
    logic                       fir_coef_write;
    logic [COEF_W-1:0]          fir_coef_data;
    logic [COEF_NUM*COEF_W-1:0] coef_o;
    logic                       coef_commit_o;
    logic                       coef_err_o;
    logic                       hist_rd_en_o;
    logic [7:0]                 hist_rd_addr_o;
    logic [BIN_W-1:0]           hist_rd_data_i = '0;
    logic                       hist_clr_o;
    logic [BIN_W-1:0]           hist_bin_data;
    logic                       hist_bin_ready;
    logic                       hist_bin_saved;
    logic                       hist_busy_o;
    logic                       hist_ovr_o;
    logic                       err_clr_i;

    int checks = 0;
    int fails  = 0;
    logic [BIN_W-1:0] exp_q[$];

    filt_cfg_ctrl #(
        .COEF_NUM(COEF_NUM), .COEF_W(COEF_W), .BIN_NUM(BIN_NUM), .BIN_W(BIN_W), .POL_VS(1)
    ) dut (
        .clk(clk), .rst(rst), .vs_i(vs_i),
        .fir_coef_write(fir_coef_write), .fir_coef_data(fir_coef_data),
        .coef_o(coef_o), .coef_commit_o(coef_commit_o), .coef_err_o(coef_err_o),
        .hist_rd_en_o(hist_rd_en_o), .hist_rd_addr_o(hist_rd_addr_o),
        .hist_rd_data_i(hist_rd_data_i), .hist_clr_o(hist_clr_o),
        .hist_bin_data(hist_bin_data), .hist_bin_ready(hist_bin_ready),
        .hist_bin_saved(hist_bin_saved), .hist_busy_o(hist_busy_o),
        .hist_ovr_o(hist_ovr_o), .err_clr_i(err_clr_i)
    );

    always #5 clk = ~clk;

    // Histogram memory model: bin content = address * 3, one-cycle latency.
    always @(posedge clk) begin
        if (hist_rd_en_o) begin
            hist_rd_data_i <= {8'h00, hist_rd_addr_o} * 16'd3;
        end
    end

    function automatic logic [COEF_W-1:0] coef_at(input int k);
        return coef_o[k*COEF_W +: COEF_W];
    endfunction

    task automatic write_coefs(input logic [COEF_W-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            fir_coef_write = 1'b1;
            fir_coef_data  = base + COEF_W'(i);
        end
        @(negedge clk);
        fir_coef_write = 1'b0;
    endtask

    task automatic pulse_vs();
        @(negedge clk);
        vs_i = 1'b1;
        @(negedge clk);
        vs_i = 1'b0;
    endtask

    task automatic pulse_err_clr();
        @(negedge clk);
        err_clr_i = 1'b1;
        @(negedge clk);
        err_clr_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (hist_busy_o && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (hist_busy_o) begin
            checks++;
            fails++;
            $display("FAIL wait_idle: busy=%0b still high after %0d cycles, required 0", hist_busy_o, n);
        end
    endtask

    task automatic test_reset();
        logic [COEF_W-1:0] e;
        rst = 1'b0; vs_i = 1'b0; fir_coef_write = 1'b0; fir_coef_data = '0;
        hist_bin_saved = 1'b0; err_clr_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int k = 0; k < COEF_NUM; k++) begin
            e = (k == COEF_NUM / 2) ? 16'd1 : 16'd0;
            checks++;
            if (coef_at(k) !== e) begin
                fails++;
                $display("FAIL reset_coef[%0d]: got %h, required %h", k, coef_at(k), e);
            end
        end
        checks++;
        if ({coef_commit_o, coef_err_o, hist_rd_en_o, hist_clr_o, hist_bin_ready, hist_busy_o, hist_ovr_o} !== 7'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b, required 0000000",
                     {coef_commit_o, coef_err_o, hist_rd_en_o, hist_clr_o, hist_bin_ready, hist_busy_o, hist_ovr_o});
        end
        checks++;
        if (hist_rd_addr_o !== 8'h00 || hist_bin_data !== 16'h0000) begin
            fails++;
            $display("FAIL reset_data: addr=%h data=%h, required 00 0000", hist_rd_addr_o, hist_bin_data);
        end
        hist_bin_saved = 1'b1;
    endtask

    task automatic test_coef_commit();
        write_coefs(16'h0100, COEF_NUM);
        pulse_vs();
        checks++;
        if (coef_commit_o !== 1'b1 || coef_err_o !== 1'b0) begin
            fails++;
            $display("FAIL commit_pulse: commit=%b err=%b, required 1 0", coef_commit_o, coef_err_o);
        end
        for (int k = 0; k < COEF_NUM; k++) begin
            checks++;
            if (coef_at(k) !== 16'h0100 + 16'(k)) begin
                fails++;
                $display("FAIL commit_coef[%0d]: got %h, required %h", k, coef_at(k), 16'h0100 + 16'(k));
            end
        end
        @(negedge clk);
        checks++;
        if (coef_commit_o !== 1'b0) begin
            fails++;
            $display("FAIL commit_once: commit=%b, required 0", coef_commit_o);
        end
        wait_idle();
    endtask

    task automatic test_partial_overflow();
        write_coefs(16'h0200, 10);
        pulse_vs();
        checks++;
        if (coef_commit_o !== 1'b0 || coef_err_o !== 1'b1 || coef_at(3) !== 16'h0103) begin
            fails++;
            $display("FAIL partial: commit=%b err=%b coef3=%h, required 0 1 0103", coef_commit_o, coef_err_o, coef_at(3));
        end
        wait_idle();
        pulse_err_clr();
        checks++;
        if (coef_err_o !== 1'b0) begin
            fails++;
            $display("FAIL err_clear: err=%b, required 0", coef_err_o);
        end
        write_coefs(16'h0300, COEF_NUM + 1);
        checks++;
        if (coef_err_o !== 1'b1) begin
            fails++;
            $display("FAIL overflow_err: err=%b, required 1", coef_err_o);
        end
        pulse_vs();
        checks++;
        if (coef_commit_o !== 1'b1) begin
            fails++;
            $display("FAIL overflow_commit: commit=%b, required 1", coef_commit_o);
        end
        for (int k = 0; k < COEF_NUM; k++) begin
            checks++;
            if (coef_at(k) !== 16'h0300 + 16'(k)) begin
                fails++;
                $display("FAIL overflow_coef[%0d]: got %h, required %h", k, coef_at(k), 16'h0300 + 16'(k));
            end
        end
        wait_idle();
    endtask

    task automatic test_coincident();
        pulse_err_clr();
        write_coefs(16'h0400, COEF_NUM);
        @(negedge clk);
        vs_i = 1'b1; fir_coef_write = 1'b1; fir_coef_data = 16'h0555;
        @(negedge clk);
        vs_i = 1'b0; fir_coef_write = 1'b0;
        checks++;
        if (coef_commit_o !== 1'b1 || coef_err_o !== 1'b0 || coef_at(0) !== 16'h0400 || coef_at(24) !== 16'h0418) begin
            fails++;
            $display("FAIL coincident_commit: commit=%b err=%b c0=%h c24=%h, required 1 0 0400 0418",
                     coef_commit_o, coef_err_o, coef_at(0), coef_at(24));
        end
        wait_idle();
        write_coefs(16'h0601, COEF_NUM - 1);
        pulse_vs();
        checks++;
        if (coef_commit_o !== 1'b1 || coef_at(0) !== 16'h0555) begin
            fails++;
            $display("FAIL coincident_next: commit=%b c0=%h, required 1 0555", coef_commit_o, coef_at(0));
        end
        for (int k = 1; k < COEF_NUM; k++) begin
            checks++;
            if (coef_at(k) !== 16'h0600 + 16'(k)) begin
                fails++;
                $display("FAIL coincident_coef[%0d]: got %h, required %h", k, coef_at(k), 16'h0600 + 16'(k));
            end
        end
        wait_idle();
    endtask

    task automatic test_dump_full();
        int ready_cnt, clr_cnt, clr_at;
        logic [BIN_W-1:0] e;
        ready_cnt = 0; clr_cnt = 0; clr_at = 0;
        hist_bin_saved = 1'b1;
        for (int b = 0; b < BIN_NUM; b++) exp_q.push_back(16'(b * 3));
        @(negedge clk);
        vs_i = 1'b1;
        for (int c = 1; c <= 800; c++) begin
            @(negedge clk);
            if (c == 1) vs_i = 1'b0;
            if (hist_bin_ready) begin
                ready_cnt++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
                checks++;
                if (hist_bin_data !== e) begin
                    fails++;
                    $display("FAIL dump_bin %0d: got %0d, required %0d", ready_cnt - 1, hist_bin_data, e);
                end
            end
            if (hist_clr_o) begin
                clr_cnt++;
                clr_at = c;
            end
        end
        checks++;
        if (ready_cnt != BIN_NUM || clr_cnt != 1 || clr_at != 769) begin
            fails++;
            $display("FAIL dump_timing: ready=%0d clr_cnt=%0d clr_at=%0d, required 256 1 769", ready_cnt, clr_cnt, clr_at);
        end
        checks++;
        if (hist_busy_o !== 1'b0 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL dump_end: busy=%b left=%0d, required 0 0", hist_busy_o, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_dump_stall();
        int acc, stall, clr_at;
        logic [BIN_W-1:0] e;
        acc = 0; stall = 0; clr_at = 0;
        hist_bin_saved = 1'b1;
        for (int b = 0; b < BIN_NUM; b++) exp_q.push_back(16'(b * 3));
        @(negedge clk);
        vs_i = 1'b1;
        for (int c = 1; c <= 820; c++) begin
            @(negedge clk);
            if (c == 1) vs_i = 1'b0;
            if (hist_bin_ready) begin
                if (acc == 7 && stall < 5) begin
                    stall++;
                    hist_bin_saved = 1'b0;
                    checks++;
                    if (hist_bin_data !== 16'd21) begin
                        fails++;
                        $display("FAIL stall_hold %0d: got %0d, required 21", stall, hist_bin_data);
                    end
                end else begin
                    hist_bin_saved = 1'b1;
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
                    acc++;
                    checks++;
                    if (hist_bin_data !== e) begin
                        fails++;
                        $display("FAIL stall_bin %0d: got %0d, required %0d", acc - 1, hist_bin_data, e);
                    end
                end
            end else begin
                hist_bin_saved = 1'b1;
            end
            if (hist_clr_o) clr_at = c;
        end
        checks++;
        if (acc != BIN_NUM || stall != 5 || clr_at != 774) begin
            fails++;
            $display("FAIL stall_timing: bins=%0d stall=%0d clr_at=%0d, required 256 5 774", acc, stall, clr_at);
        end
        exp_q.delete();
        hist_bin_saved = 1'b1;
    endtask

    task automatic test_overrun_reset();
        int ready_cnt, clr_at;
        logic [BIN_W-1:0] e;
        ready_cnt = 0; clr_at = 0;
        pulse_err_clr();
        for (int b = 0; b < BIN_NUM; b++) exp_q.push_back(16'(b * 3));
        @(negedge clk);
        vs_i = 1'b1;
        for (int c = 1; c <= 800; c++) begin
            @(negedge clk);
            if (c == 1 || c == 101) vs_i = 1'b0;
            if (c == 100) vs_i = 1'b1;
            if (c == 102) begin
                checks++;
                if (hist_ovr_o !== 1'b1) begin
                    fails++;
                    $display("FAIL ovr_set: ovr=%b, required 1", hist_ovr_o);
                end
            end
            if (hist_bin_ready) begin
                ready_cnt++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
                checks++;
                if (hist_bin_data !== e) begin
                    fails++;
                    $display("FAIL ovr_bin %0d: got %0d, required %0d", ready_cnt - 1, hist_bin_data, e);
                end
            end
            if (hist_clr_o) clr_at = c;
        end
        checks++;
        if (ready_cnt != BIN_NUM || clr_at != 769 || hist_ovr_o !== 1'b1) begin
            fails++;
            $display("FAIL ovr_dump: ready=%0d clr_at=%0d ovr=%b, required 256 769 1", ready_cnt, clr_at, hist_ovr_o);
        end
        exp_q.delete();
        pulse_vs();
        repeat (50) @(negedge clk);
        checks++;
        if (hist_busy_o !== 1'b1) begin
            fails++;
            $display("FAIL mid_busy: busy=%b, required 1", hist_busy_o);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({coef_commit_o, coef_err_o, hist_rd_en_o, hist_clr_o, hist_bin_ready, hist_busy_o, hist_ovr_o} !== 7'b0
            || hist_rd_addr_o !== 8'h00 || hist_bin_data !== 16'h0000 || coef_at(12) !== 16'd1 || coef_at(0) !== 16'd0) begin
            fails++;
            $display("FAIL async_reset: ctrl=%b addr=%h data=%h c12=%h c0=%h, required 0000000 00 0000 0001 0000",
                     {coef_commit_o, coef_err_o, hist_rd_en_o, hist_clr_o, hist_bin_ready, hist_busy_o, hist_ovr_o},
                     hist_rd_addr_o, hist_bin_data, coef_at(12), coef_at(0));
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (hist_busy_o !== 1'b0 || hist_bin_ready !== 1'b0 || hist_rd_en_o !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_idle: busy=%b ready=%b rd_en=%b, required 0 0 0", hist_busy_o, hist_bin_ready, hist_rd_en_o);
        end
    endtask

    initial begin
        test_reset();
        test_coef_commit();
        test_partial_overflow();
        test_coincident();
        test_dump_full();
        test_dump_stall();
        test_overrun_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
